// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: decode/writeback/memory status in, per-register stall/flush out.
// The core side uses the master modport, the hazard controller the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int RAW    = 5
);
    logic              imem_wait;
    logic              dmem_wait;
    logic              redirect;
    logic              csr_inflight;
    logic              id_valid;
    logic              id_csr;
    logic [RAW-1:0]    id_rs1;
    logic [RAW-1:0]    id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [RAW-1:0]    id_rd;
    logic              id_wen;
    logic              id_late;
    logic              wb_valid;
    logic [RAW-1:0]    wb_rd;
    logic              wb_late;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              issue;
    logic              redirect_take;

    modport master (
        output imem_wait, dmem_wait, redirect, csr_inflight,
        output id_valid, id_csr, id_rs1, id_rs2, id_use1, id_use2,
        output id_rd, id_wen, id_late, wb_valid, wb_rd, wb_late,
        input  stall, flush, issue, redirect_take
    );

    modport slave (
        input  imem_wait, dmem_wait, redirect, csr_inflight,
        input  id_valid, id_csr, id_rs1, id_rs2, id_use1, id_use2,
        input  id_rd, id_wen, id_late, wb_valid, wb_rd, wb_late,
        output stall, flush, issue, redirect_take
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an in-order NSTAGE pipeline with a late-writer scoreboard,
// CSR serialisation and sticky redirect. Optional PIPE_HAZARD_PERF_EN adds saturating event counters.
module pipe_hazard_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int DEC_IDX = 2,
    parameter int NREG    = 32,
    parameter int RAW     = 5
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_raw,
    output logic [31:0]         perf_redir,
    output logic [31:0]         perf_mem
`endif
);

    typedef enum logic [2:0] {
        PRI_RST   = 3'd0,
        PRI_IDLE  = 3'd1,
        PRI_MEM   = 3'd2,
        PRI_REDIR = 3'd3,
        PRI_HAZ   = 3'd4,
        PRI_IFW   = 3'd5
    } pri_e;

    localparam logic [NSTAGE-1:0] MASK_PC   = {{(NSTAGE-1){1'b0}}, 1'b1};
    localparam logic [NSTAGE-1:0] MASK_IFID = {{(NSTAGE-2){1'b0}}, 2'b10};

    // One-hot of a register index; x0 is never tracked so its bit is forced low.
    function automatic logic [NREG-1:0] reg_onehot(input logic [RAW-1:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        v[0]   = 1'b0;
        return v;
    endfunction

    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;
    logic [NREG-1:0]   busy_eff_s;
    logic [NREG-1:0]   clr_vec_s;
    logic [NREG-1:0]   set_vec_s;
    logic              redir_pend_r;
    logic              redir_pend_nxt_s;
    logic              hazard_s;
    logic              pend_ovr_s;
    pri_e              pri_s;
    logic [NSTAGE-1:0] stall_base_s;
    logic [NSTAGE-1:0] flush_base_s;
    logic [NSTAGE-1:0] stall_s;
    logic [NSTAGE-1:0] flush_s;
    logic              issue_s;
    logic              take_s;

    // Writeback clear is visible to decode in the same cycle, so a retiring load never costs a stall.
    always_comb begin
        clr_vec_s = {NREG{1'b0}};
        if (hz.wb_valid && hz.wb_late) begin
            clr_vec_s = reg_onehot(hz.wb_rd);
        end else begin
            clr_vec_s = {NREG{1'b0}};
        end
        busy_eff_s = busy_r & ~clr_vec_s;
    end

    // Hazard detection: RAW on either source, WAW against an in-flight late writer, CSR serialisation.
    always_comb begin
        hazard_s = hz.id_valid &
                   ((hz.id_use1 & busy_eff_s[hz.id_rs1]) |
                    (hz.id_use2 & busy_eff_s[hz.id_rs2]) |
                    (hz.id_wen & hz.id_late & busy_eff_s[hz.id_rd]) |
                    (hz.id_csr & hz.csr_inflight));
    end

    // Priority select; reset forces every output low regardless of inputs.
    always_comb begin
        pri_s = PRI_IDLE;
        if (!reset) begin
            pri_s = PRI_RST;
        end else if (hz.dmem_wait) begin
            pri_s = PRI_MEM;
        end else if (hz.redirect) begin
            pri_s = PRI_REDIR;
        end else if (hazard_s) begin
            pri_s = PRI_HAZ;
        end else if (hz.imem_wait) begin
            pri_s = PRI_IFW;
        end else begin
            pri_s = PRI_IDLE;
        end
    end

    // Base stall/flush/issue pattern for the selected priority case.
    always_comb begin
        stall_base_s = {NSTAGE{1'b0}};
        flush_base_s = {NSTAGE{1'b0}};
        issue_s      = 1'b0;
        take_s       = 1'b0;
        case (pri_s)
            PRI_RST: begin
                issue_s = 1'b0;
            end
            PRI_MEM: begin
                stall_base_s = {NSTAGE{1'b1}};
            end
            PRI_REDIR: begin
                take_s = 1'b1;
                for (int k = 1; k <= DEC_IDX; k++) begin
                    flush_base_s[k] = 1'b1;
                end
            end
            PRI_HAZ: begin
                for (int k = 0; k < DEC_IDX; k++) begin
                    stall_base_s[k] = 1'b1;
                end
                flush_base_s[DEC_IDX] = 1'b1;
            end
            PRI_IFW: begin
                stall_base_s = MASK_PC;
                flush_base_s = MASK_IFID;
                issue_s      = hz.id_valid;
            end
            PRI_IDLE: begin
                issue_s = hz.id_valid;
            end
            default: begin
                stall_base_s = {NSTAGE{1'b0}};
                flush_base_s = {NSTAGE{1'b0}};
                issue_s      = 1'b0;
                take_s       = 1'b0;
            end
        endcase
    end

    // A pending redirect keeps the pc held and drops whatever lands in IF/ID; IF/ID is never held then,
    // so stall and flush stay exclusive.
    assign pend_ovr_s = redir_pend_r & ((pri_s == PRI_HAZ) | (pri_s == PRI_IFW) | (pri_s == PRI_IDLE));
    assign stall_s    = pend_ovr_s ? ((stall_base_s & ~MASK_IFID) | MASK_PC) : stall_base_s;
    assign flush_s    = pend_ovr_s ? (flush_base_s | MASK_IFID) : flush_base_s;

    assign hz.stall         = stall_s;
    assign hz.flush         = flush_s;
    assign hz.issue         = issue_s;
    assign hz.redirect_take = take_s;

    // Scoreboard next state: set wins over a same-cycle clear of the same register.
    always_comb begin
        set_vec_s = {NREG{1'b0}};
        if (issue_s && hz.id_wen && hz.id_late) begin
            set_vec_s = reg_onehot(hz.id_rd);
        end else begin
            set_vec_s = {NREG{1'b0}};
        end
        busy_nxt_s       = busy_eff_s | set_vec_s;
        redir_pend_nxt_s = hz.imem_wait & (redir_pend_r | take_s);
    end

    // Scoreboard and redirect-pending registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r       <= {NREG{1'b0}};
            redir_pend_r <= 1'b0;
        end else begin
            busy_r       <= busy_nxt_s;
            redir_pend_r <= redir_pend_nxt_s;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_raw_r;
    logic [31:0] perf_redir_r;
    logic [31:0] perf_mem_r;

    // Saturating cycle counters for hazard, redirect and memory-wait priority cases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_raw_r   <= 32'd0;
            perf_redir_r <= 32'd0;
            perf_mem_r   <= 32'd0;
        end else begin
            if ((pri_s == PRI_HAZ) && (perf_raw_r != 32'hFFFF_FFFF)) begin
                perf_raw_r <= perf_raw_r + 32'd1;
            end else begin
                perf_raw_r <= perf_raw_r;
            end
            if ((pri_s == PRI_REDIR) && (perf_redir_r != 32'hFFFF_FFFF)) begin
                perf_redir_r <= perf_redir_r + 32'd1;
            end else begin
                perf_redir_r <= perf_redir_r;
            end
            if ((pri_s == PRI_MEM) && (perf_mem_r != 32'hFFFF_FFFF)) begin
                perf_mem_r <= perf_mem_r + 32'd1;
            end else begin
                perf_mem_r <= perf_mem_r;
            end
        end
    end

    assign perf_raw   = perf_raw_r;
    assign perf_redir = perf_redir_r;
    assign perf_mem   = perf_mem_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NSTAGE=5, DEC_IDX=2) with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pipe_hazard_ctrl_if #(.NSTAGE(5), .RAW(5)) hz_bus ();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_raw;
    logic [31:0] perf_redir;
    logic [31:0] perf_mem;
`endif

    pipe_hazard_ctrl #(.NSTAGE(5), .DEC_IDX(2), .NREG(32), .RAW(5)) dut (
        .clk   (clk),
        .reset (rst_n),
        .hz    (hz_bus)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_raw   (perf_raw),
        .perf_redir (perf_redir),
        .perf_mem   (perf_mem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] st, input logic [4:0] fl,
                           input logic is, input logic tk);
        chk({tag, ".stall"}, {27'd0, hz_bus.stall}, {27'd0, st});
        chk({tag, ".flush"}, {27'd0, hz_bus.flush}, {27'd0, fl});
        chk({tag, ".issue"}, {31'd0, hz_bus.issue}, {31'd0, is});
        chk({tag, ".take"}, {31'd0, hz_bus.redirect_take}, {31'd0, tk});
    endtask

    task automatic idle_in();
        hz_bus.imem_wait    = 1'b0;
        hz_bus.dmem_wait    = 1'b0;
        hz_bus.redirect     = 1'b0;
        hz_bus.csr_inflight = 1'b0;
        hz_bus.id_valid     = 1'b0;
        hz_bus.id_csr       = 1'b0;
        hz_bus.id_rs1       = 5'd0;
        hz_bus.id_rs2       = 5'd0;
        hz_bus.id_use1      = 1'b0;
        hz_bus.id_use2      = 1'b0;
        hz_bus.id_rd        = 5'd0;
        hz_bus.id_wen       = 1'b0;
        hz_bus.id_late      = 1'b0;
        hz_bus.wb_valid     = 1'b0;
        hz_bus.wb_rd        = 5'd0;
        hz_bus.wb_late      = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are then changed and sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic late_writer(input logic [4:0] rd);
        idle_in();
        hz_bus.id_valid = 1'b1;
        hz_bus.id_wen   = 1'b1;
        hz_bus.id_late  = 1'b1;
        hz_bus.id_rd    = rd;
    endtask

    task automatic use_rs1(input logic [4:0] rs);
        idle_in();
        hz_bus.id_valid = 1'b1;
        hz_bus.id_use1  = 1'b1;
        hz_bus.id_rs1   = rs;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_in();
        hz_bus.id_valid     = 1'b1;
        hz_bus.id_csr       = 1'b1;
        hz_bus.csr_inflight = 1'b1;
        hz_bus.dmem_wait    = 1'b1;
        #1;
        chk_out("reset", 5'b00000, 5'b00000, 1'b0, 1'b0);
        #20;
        idle_in();
        rst_n = 1'b1;

        // Idle and plain fetch wait
        cyc(); idle_in(); hz_bus.id_valid = 1'b1; #1;
        chk_out("idle", 5'b00000, 5'b00000, 1'b1, 1'b0);
        hz_bus.imem_wait = 1'b1; #1;
        chk_out("imem_wait", 5'b00001, 5'b00010, 1'b1, 1'b0);

        // Load x5 then a dependent use until writeback
        cyc(); late_writer(5'd5); #1;
        chk_out("ld5_issue", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); use_rs1(5'd5); #1;
        chk_out("raw5_a", 5'b00011, 5'b00100, 1'b0, 1'b0);
        cyc(); use_rs1(5'd5); #1;
        chk_out("raw5_b", 5'b00011, 5'b00100, 1'b0, 1'b0);
        cyc(); use_rs1(5'd5);
        hz_bus.wb_valid = 1'b1; hz_bus.wb_late = 1'b1; hz_bus.wb_rd = 5'd5; #1;
        chk_out("raw5_wb", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); use_rs1(5'd5); #1;
        chk_out("raw5_done", 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Same-cycle set and clear of x7: set wins
        cyc(); late_writer(5'd7);
        hz_bus.wb_valid = 1'b1; hz_bus.wb_late = 1'b1; hz_bus.wb_rd = 5'd7; #1;
        chk_out("x7_setclr", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); idle_in();
        hz_bus.id_valid = 1'b1; hz_bus.id_use2 = 1'b1; hz_bus.id_rs2 = 5'd7; #1;
        chk_out("x7_busy", 5'b00011, 5'b00100, 1'b0, 1'b0);
        // WAW against the in-flight x7 writer
        hz_bus.id_use2 = 1'b0; hz_bus.id_wen = 1'b1; hz_bus.id_late = 1'b1; hz_bus.id_rd = 5'd7; #1;
        chk_out("x7_waw", 5'b00011, 5'b00100, 1'b0, 1'b0);
        hz_bus.wb_valid = 1'b1; hz_bus.wb_late = 1'b1; hz_bus.wb_rd = 5'd7;
        hz_bus.id_wen = 1'b0; hz_bus.id_late = 1'b0; hz_bus.id_use2 = 1'b1; #1;
        chk_out("x7_bypass", 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Late writer to x0 leaves the scoreboard untouched
        cyc(); late_writer(5'd0); #1;
        chk_out("x0_issue", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); late_writer(5'd0); hz_bus.id_use1 = 1'b1; hz_bus.id_rs1 = 5'd0; #1;
        chk_out("x0_nohaz", 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Redirect with a fetch outstanding for three cycles
        cyc(); idle_in();
        hz_bus.redirect = 1'b1; hz_bus.imem_wait = 1'b1; hz_bus.id_valid = 1'b1; #1;
        chk_out("redir", 5'b00000, 5'b00110, 1'b0, 1'b1);
        cyc(); idle_in(); hz_bus.imem_wait = 1'b1; #1;
        chk_out("redir_w1", 5'b00001, 5'b00010, 1'b0, 1'b0);
        cyc(); idle_in(); hz_bus.imem_wait = 1'b1; #1;
        chk_out("redir_w2", 5'b00001, 5'b00010, 1'b0, 1'b0);
        cyc(); idle_in(); #1;
        chk_out("redir_drop", 5'b00001, 5'b00010, 1'b0, 1'b0);
        cyc(); idle_in(); #1;
        chk_out("redir_clr", 5'b00000, 5'b00000, 1'b0, 1'b0);

        // Memory wait dominates redirect and hazard
        cyc(); idle_in();
        hz_bus.dmem_wait = 1'b1; hz_bus.redirect = 1'b1; hz_bus.id_valid = 1'b1;
        hz_bus.id_csr = 1'b1; hz_bus.csr_inflight = 1'b1; #1;
        chk_out("dmem_prio", 5'b11111, 5'b00000, 1'b0, 1'b0);
        // The held redirect must not have armed the pending flag
        cyc(); idle_in(); #1;
        chk_out("dmem_after", 5'b00000, 5'b00000, 1'b0, 1'b0);

        // CSR serialisation: two bubbles then issue
        for (int i = 0; i < 2; i++) begin
            cyc(); idle_in();
            hz_bus.id_valid = 1'b1; hz_bus.id_csr = 1'b1; hz_bus.csr_inflight = 1'b1; #1;
            chk_out("csr_bubble", 5'b00011, 5'b00100, 1'b0, 1'b0);
        end
        cyc(); idle_in(); hz_bus.id_valid = 1'b1; hz_bus.id_csr = 1'b1; #1;
        chk_out("csr_issue", 5'b00000, 5'b00000, 1'b1, 1'b0);

        // Reset in the middle of a hazard on x3
        cyc(); late_writer(5'd3); #1;
        chk_out("ld3_issue", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); use_rs1(5'd3); #1;
        chk_out("raw3", 5'b00011, 5'b00100, 1'b0, 1'b0);
        rst_n = 1'b0; #1;
        chk_out("raw3_rst", 5'b00000, 5'b00000, 1'b0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_raw_rst", perf_raw, 32'd0);
        chk("perf_redir_rst", perf_redir, 32'd0);
        chk("perf_mem_rst", perf_mem, 32'd0);
`endif
        #3;
        rst_n = 1'b1; #1;
        chk_out("raw3_clear", 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc(); #1;
        chk_out("raw3_idle", 5'b00000, 5'b00000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
